soldier_spawner: RTL and testbench
==================================

SOLDIER_SPAWNER -- requirements
Module: soldier_spawner

Interface
REQ-001 SHALL have parameter NSLOT, default 4: number of soldier slots shared by both players.
REQ-002 SHALL have parameter MAX_PER_SIDE, default 3: maximum live soldiers per player.
REQ-003 SHALL have parameter COOLDOWN, default 8: per-player cycles loaded after a grant.
REQ-004 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port game_en, input, 1: grants allowed and cooldowns count only while high.
REQ-007 SHALL have port clear, input, 1: synchronous round-over; frees all slots.
REQ-008 SHALL have port spawn_req, input, 2: bit0 = player A (left, dir 1), bit1 = player B (right, dir 0); level requests.
REQ-009 SHALL have port kill, input, NSLOT: one-cycle pulse per slot marking that soldier dead.
REQ-010 SHALL have port slot_valid, output, NSLOT: registered valid to each soldier instance.
REQ-011 SHALL have port slot_dir, output, NSLOT: registered direction to each soldier; 1 = player A.
REQ-012 SHALL have port spawn_ack, output, 2: one-cycle registered pulse to the granted player.
REQ-013 SHALL have port grant_slot, output, clog2(NSLOT): index of the slot granted, valid while spawn_ack != 0.
REQ-014 SHALL have ports count_a and count_b, output, clog2(MAX_PER_SIDE+1) each: live soldier count per player.

Function
REQ-015 Player p SHALL be eligible when spawn_req[p]=1, game_en=1, clear=0, cooldown_p=0, count_p<MAX_PER_SIDE, and at least one slot has slot_valid=0.
REQ-016 At most one grant SHALL occur per cycle; if both players are eligible, the round-robin pointer SHALL choose (reset value: player A), and the pointer SHALL move to the other player after every grant.
REQ-017 The granted slot SHALL be the lowest-index slot with slot_valid=0 in the current cycle; a slot killed in the same cycle SHALL NOT be reusable until the next cycle.
REQ-018 On a grant at edge k, at edge k the block SHALL set slot_valid[s]=1 and slot_dir[s]=(p==A), drive spawn_ack[p]=1 and grant_slot=s for one cycle, increment count_p, and load cooldown_p=COOLDOWN.
REQ-019 cooldown_p SHALL decrement by 1 per cycle while nonzero and game_en=1, and SHALL hold while game_en=0; consecutive grants to one player SHALL therefore be at least COOLDOWN+1 edges apart.
REQ-020 kill[s] with slot_valid[s]=1 SHALL clear slot_valid[s] at the next edge and decrement the owner count selected by slot_dir[s]; kill on an invalid slot SHALL be ignored.
REQ-021 A kill and a grant on different slots in one cycle SHALL both take effect, including when both affect the same player's count (net change 0).
REQ-022 Because a freed slot is reused no earlier than one cycle after its kill, slot_valid SHALL be low for at least one full cycle between occupants, which re-initialises the soldier.
REQ-023 slot_dir SHALL hold its value while slot_valid=0.
REQ-024 clear=1 SHALL take priority over grants and kills: at the next edge all slot_valid=0, counts=0, cooldowns=0, spawn_ack=0, and the pointer=A.
REQ-025 Counts SHALL never exceed MAX_PER_SIDE or wrap below 0.

Reset
REQ-026 While rst_n=0, asynchronously: slot_valid=0, slot_dir=0, spawn_ack=0, grant_slot=0, count_a=count_b=0, cooldowns=0, pointer=A.
REQ-027 If rst_n is asserted mid-grant, no spawn_ack or slot_valid SHALL survive; the first grant SHALL be possible on the first edge after rst_n deasserts.

Verification
REQ-028 Test 1: spawn_req=01 held, game_en=1 -> ack A with slot 0 at edge 1 and slot 1 at edge 10; slot_dir=1 for both; count_a steps to 1, then 2.
REQ-029 Test 2: spawn_req=11 from reset -> edge 1 grants A slot 0, edge 2 grants B slot 1 (slot_dir[1]=0), and never two acks in one cycle.
REQ-030 Test 3: A has 3 live soldiers with spawn_req A held -> no ack; kill[0] pulse -> count_a=2 next edge, slot 0 re-granted one edge later.
REQ-031 Test 4: all 4 slots full, spawn_req=11 -> no grants; kill[2] and a new request in the same cycle -> slot 2 granted only on the following edge.
REQ-032 Test 5: game_en=0 with cooldown_a=5 for 10 cycles -> cooldown_a holds at 5; clear pulse -> all slot_valid=0 and counts=0 next edge.
REQ-033 Test 6: rst_n=0 asserted asynchronously between edges mid-operation -> all outputs read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/soldier_spawner.sv
// Shared soldier-slot allocator for two players: round-robin grants into the lowest free slot,
// per-player live-count limits, per-player cooldowns, and per-slot kill handling.
module soldier_spawner #(
    parameter int unsigned NSLOT        = 4,
    parameter int unsigned MAX_PER_SIDE = 3,
    parameter int unsigned COOLDOWN     = 8,
    localparam int unsigned SW  = (NSLOT > 1) ? $clog2(NSLOT) : 1,
    localparam int unsigned CW  = $clog2(MAX_PER_SIDE + 1),
    localparam int unsigned CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             game_en,
    input  logic             clear,
    input  logic [1:0]       spawn_req,
    input  logic [NSLOT-1:0] kill,
    output logic [NSLOT-1:0] slot_valid,
    output logic [NSLOT-1:0] slot_dir,
    output logic [1:0]       spawn_ack,
    output logic [SW-1:0]    grant_slot,
    output logic [CW-1:0]    count_a,
    output logic [CW-1:0]    count_b
);

    localparam logic [CW-1:0]  MaxCnt = CW'(MAX_PER_SIDE);
    localparam logic [CDW-1:0] CdLoad = CDW'(COOLDOWN);

    typedef enum logic {PtrA, PtrB} ptr_e;

    logic [NSLOT-1:0] slot_valid_q, slot_valid_d;
    logic [NSLOT-1:0] slot_dir_q, slot_dir_d;
    logic [1:0]       ack_q, ack_d;
    logic [SW-1:0]    grant_slot_q, grant_slot_d;
    logic [CW-1:0]    count_a_q, count_a_d, count_b_q, count_b_d;
    logic [CDW-1:0]   cd_a_q, cd_a_d, cd_b_q, cd_b_d;
    ptr_e             ptr_q, ptr_d;

    logic             free_found;
    logic [SW-1:0]    free_idx;
    logic [CW-1:0]    kills_a, kills_b;
    logic             elig_a, elig_b, grant_a, grant_b;

    // Search and kill tally use registered slot_valid, so a slot killed this cycle stays
    // unavailable until the next one.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        kills_a    = '0;
        kills_b    = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (!slot_valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
            if (kill[i] && slot_valid_q[i]) begin
                if (slot_dir_q[i]) kills_a = kills_a + CW'(1);
                else               kills_b = kills_b + CW'(1);
            end
        end
    end

    always_comb begin
        elig_a  = spawn_req[0] & game_en & ~clear & (cd_a_q == '0) & (count_a_q < MaxCnt)
                  & free_found;
        elig_b  = spawn_req[1] & game_en & ~clear & (cd_b_q == '0) & (count_b_q < MaxCnt)
                  & free_found;
        grant_a = elig_a & (~elig_b | (ptr_q == PtrA));
        grant_b = elig_b & ~grant_a;
    end

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_dir_d   = slot_dir_q;
        ack_d        = '0;
        grant_slot_d = grant_slot_q;
        count_a_d    = count_a_q;
        count_b_d    = count_b_q;
        cd_a_d       = cd_a_q;
        cd_b_d       = cd_b_q;
        ptr_d        = ptr_q;

        if (clear) begin
            slot_valid_d = '0;
            count_a_d    = '0;
            count_b_d    = '0;
            cd_a_d       = '0;
            cd_b_d       = '0;
            ptr_d        = PtrA;
        end else begin
            slot_valid_d = slot_valid_q & ~kill;
            count_a_d    = count_a_q - kills_a;
            count_b_d    = count_b_q - kills_b;

            if (grant_a)                      cd_a_d = CdLoad;
            else if (game_en && cd_a_q != '0) cd_a_d = cd_a_q - CDW'(1);
            if (grant_b)                      cd_b_d = CdLoad;
            else if (game_en && cd_b_q != '0) cd_b_d = cd_b_q - CDW'(1);

            if (grant_a || grant_b) begin
                slot_valid_d[free_idx] = 1'b1;
                slot_dir_d[free_idx]   = grant_a;
                ack_d                  = {grant_b, grant_a};
                grant_slot_d           = free_idx;
                ptr_d                  = grant_a ? PtrB : PtrA;
                if (grant_a) count_a_d = count_a_d + CW'(1);
                else         count_b_d = count_b_d + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q <= '0;
            slot_dir_q   <= '0;
            ack_q        <= '0;
            grant_slot_q <= '0;
            count_a_q    <= '0;
            count_b_q    <= '0;
            cd_a_q       <= '0;
            cd_b_q       <= '0;
            ptr_q        <= PtrA;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_dir_q   <= slot_dir_d;
            ack_q        <= ack_d;
            grant_slot_q <= grant_slot_d;
            count_a_q    <= count_a_d;
            count_b_q    <= count_b_d;
            cd_a_q       <= cd_a_d;
            cd_b_q       <= cd_b_d;
            ptr_q        <= ptr_d;
        end
    end

    assign slot_valid = slot_valid_q;
    assign slot_dir   = slot_dir_q;
    assign spawn_ack  = ack_q;
    assign grant_slot = grant_slot_q;
    assign count_a    = count_a_q;
    assign count_b    = count_b_q;

endmodule

// File: tb/tb_soldier_spawner.sv
// Bench for soldier_spawner: directed scenarios plus random traffic, checked against a
// slot-occupancy model; grants go through an expected-ack queue popped by a monitor.
module tb_soldier_spawner;

    localparam int NSLOT = 4;
    localparam int MAXS  = 3;
    localparam int CD    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             game_en = 1'b0;
    logic             clear = 1'b0;
    logic [1:0]       spawn_req = '0;
    logic [NSLOT-1:0] kill = '0;
    logic [NSLOT-1:0] slot_valid, slot_dir;
    logic [1:0]       spawn_ack;
    logic [1:0]       grant_slot;
    logic [1:0]       count_a, count_b;

    soldier_spawner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .game_en   (game_en),
        .clear     (clear),
        .spawn_req (spawn_req),
        .kill      (kill),
        .slot_valid(slot_valid),
        .slot_dir  (slot_dir),
        .spawn_ack (spawn_ack),
        .grant_slot(grant_slot),
        .count_a   (count_a),
        .count_b   (count_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0] ack;
        logic [1:0] slot;
    } exp_t;
    exp_t exp_q[$];

    // Model: which slots hold a soldier, who owns each slot, cooldown per player, next pick.
    bit [NSLOT-1:0] m_occ = '0;
    bit [NSLOT-1:0] m_own = '0;
    int             m_cd[2] = '{0, 0};
    int             m_ptr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int live(input int p);
        int n = 0;
        for (int s = 0; s < NSLOT; s++) if (m_occ[s] && (m_own[s] == (p == 0))) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_occ = '0; m_own = '0; m_cd[0] = 0; m_cd[1] = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        int  free = -1;
        bit  el[2];
        int  g = -1;
        for (int s = NSLOT - 1; s >= 0; s--) if (!m_occ[s]) free = s;
        if (clear) begin
            m_occ = '0; m_cd[0] = 0; m_cd[1] = 0; m_ptr = 0;
            return;
        end
        for (int p = 0; p < 2; p++)
            el[p] = spawn_req[p] && game_en && m_cd[p] == 0 && live(p) < MAXS && free >= 0;
        if (el[0] && el[1]) g = m_ptr;
        else if (el[0])     g = 0;
        else if (el[1])     g = 1;
        for (int p = 0; p < 2; p++)
            if (p == g) m_cd[p] = CD;
            else if (game_en && m_cd[p] > 0) m_cd[p]--;
        for (int s = 0; s < NSLOT; s++) if (kill[s]) m_occ[s] = 1'b0;
        if (g >= 0) begin
            m_occ[free] = 1'b1;
            m_own[free] = (g == 0);
            m_ptr       = 1 - g;
            exp_q.push_back('{ack: (g == 0) ? 2'b01 : 2'b10, slot: 2'(free)});
        end
    endtask

    task automatic check_state();
        chk("slot_valid", slot_valid, m_occ);
        chk("slot_dir", slot_dir, m_own);
        chk("count_a", count_a, live(0));
        chk("count_b", count_b, live(1));
    endtask

    // Drive one cycle's inputs, advance the model, then sample after the following negedge.
    task automatic cycle(input logic ge, input logic clr, input logic [1:0] req,
                         input logic [NSLOT-1:0] kl);
        game_en = ge; clear = clr; spawn_req = req; kill = kl;
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
        check_state();
    endtask

    always @(negedge clk) begin
        if (rst_n && spawn_ack != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", spawn_ack, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("spawn_ack", spawn_ack, e.ack);
                chk("grant_slot", grant_slot, e.slot);
            end
        end
    end

    initial begin
        logic [NSLOT-1:0] kl;
        logic             ge, clr;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid", slot_valid, 0);
        chk("reset_ack", spawn_ack, 0);
        chk("reset_grant_slot", grant_slot, 0);
        check_state();
        rst_n = 1'b1;

        // A alone: grants at edge 1 (slot 0) and edge 10 (slot 1)
        cycle(1, 0, 2'b01, '0);
        chk("t1_count_edge1", count_a, 1);
        repeat (8) cycle(1, 0, 2'b01, '0);
        chk("t1_count_edge9", count_a, 1);
        cycle(1, 0, 2'b01, '0);
        chk("t1_valid_edge10", slot_valid, 4'b0011);
        chk("t1_dir_edge10", slot_dir, 4'b0011);

        // Both request: A then B
        cycle(1, 1, 2'b00, '0);
        cycle(1, 0, 2'b11, '0);
        cycle(1, 0, 2'b11, '0);
        chk("t2_valid", slot_valid, 4'b0011);
        chk("t2_dir", slot_dir, 4'b0001);
        chk("t2_count_b", count_b, 1);

        // A fills to its limit, then a kill frees slot 0 for reuse one edge later
        cycle(1, 1, 2'b00, '0);
        repeat (29) cycle(1, 0, 2'b01, '0);
        chk("t3_count_a_max", count_a, 3);
        cycle(1, 0, 2'b01, 4'b0001);
        chk("t3_count_after_kill", count_a, 2);
        chk("t3_valid_after_kill", slot_valid, 4'b0110);
        cycle(1, 0, 2'b01, '0);
        chk("t3_regrant", slot_valid, 4'b0111);

        // All slots full; kill with request in the same cycle, slot 2 granted next edge
        cycle(1, 0, 2'b10, '0);
        chk("t4_full", slot_valid, 4'b1111);
        repeat (10) cycle(1, 0, 2'b11, '0);
        cycle(1, 0, 2'b11, 4'b0100);
        chk("t4_kill_no_same_cycle_reuse", slot_valid, 4'b1011);
        cycle(1, 0, 2'b11, '0);
        chk("t4_slot2_regrant", slot_valid, 4'b1111);

        // Cooldown freezes while game_en is low
        cycle(1, 1, 2'b00, '0);
        cycle(1, 0, 2'b01, '0);
        repeat (3) cycle(1, 0, 2'b00, '0);
        repeat (10) cycle(0, 0, 2'b01, '0);
        repeat (5) cycle(1, 0, 2'b01, '0);
        chk("t5_still_cooling", count_a, 1);
        cycle(1, 0, 2'b01, '0);
        chk("t5_grant_after_hold", count_a, 2);
        cycle(1, 1, 2'b11, 4'b0011);
        chk("t5_clear_valid", slot_valid, 0);
        chk("t5_clear_count", count_a, 0);

        // Asynchronous reset while an ack is being presented
        game_en = 1; clear = 0; spawn_req = 2'b11; kill = '0;
        model_step();
        @(posedge clk);
        #2;
        chk("t6_ack_before_reset", spawn_ack, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", slot_valid, 0);
        chk("t6_dir", slot_dir, 0);
        chk("t6_ack", spawn_ack, 0);
        chk("t6_grant_slot", grant_slot, 0);
        chk("t6_counts", {count_a, count_b}, 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 0, 2'b11, '0);
        chk("t6_first_grant", slot_valid, 4'b0001);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int s = 0; s < NSLOT; s++) kl[s] = ($urandom_range(0, 4) == 0);
            ge  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 49) == 0);
            cycle(ge, clr, 2'($urandom), kl);
        end

        chk("pending_acks", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
